rgb_palette_sequencer: RTL and testbench
========================================

// Module: rgb_palette_sequencer
// PURPOSE
//  Parametrised RGB colour sequencer driving the per-channel PWM duty inputs.
//  - Steps through a writable palette of N_COLORS entries.
//  - Two modes: hard STEP between colours, or linear FADE from one colour to the next.
//  - Sits between the control/register logic and the three PWM generators.
// PARAMETERS
//  CW        8           channel duty width, bits
//  N_COLORS  8           palette depth (>=2)
//  IW        3           index width, $clog2(N_COLORS)
//  TICK_DIV  62_500_000  clk cycles per tick (>=2)
//  HOLD_LOG2 2           ticks per colour = 2**HOLD_LOG2 (also fade resolution)
// PORTS
//  clk        in   1       system clock
//  rst        in   1       synchronous reset, active-low (0 = reset)
//  en         in   1       1 = run; 0 = off (outputs 0, index held)
//  mode       in   1       0 = STEP, 1 = FADE; sampled at colour boundaries only
//  n_active   in   IW+1    number of palette entries used, clamped to 1..N_COLORS
//  pal_we     in   1       palette write strobe
//  pal_addr   in   IW      palette write address; addr >= N_COLORS ignored
//  pal_data   in   3*CW    {R,G,B} write data
//  r_out      out  CW      red duty
//  g_out      out  CW      green duty
//  b_out      out  CW      blue duty
//  color_idx  out  IW      index of current (source) colour
//  wrap       out  1       1-cycle pulse when index wraps n_active-1 -> 0
// BEHAVIOUR
//  Reset (rst=0 at posedge)
//  - r/g/b_out=0, color_idx=0, wrap=0, prescaler=0, k=0, state OFF, latched mode=STEP.
//  - Palette loads defaults 0..6: {255,0,0} {255,60,0} {255,255,0} {0,255,0}
//    {0,0,255} {8,46,84} {160,32,240} (scaled by CW-8 left shift); others 0.
//  - Reset wins over every other input, including mid-fade.
//  Prescaler
//  - Counts 0..TICK_DIV-1 while en=1.
//  - tick=1 on the cycle the count equals TICK_DIV-1.
//  - en=0 clears prescaler and k.
//  FSM states
//  - OFF: outputs 0, no ticks. en=1 -> RUN, latching mode.
//  - RUN: k counts ticks 0..2**HOLD_LOG2-1.
//  - On tick with k at max: k=0, idx=nxt, mode re-latched.
//  - RUN with en=0 -> OFF, color_idx retained.
//  Sequencing
//  - nxt = (idx >= na-1) ? 0 : idx+1, with na = clamped n_active.
//  - Shrinking n_active below idx+1 wraps at the next boundary.
//  - wrap pulses on the boundary where idx goes to 0 from a nonzero value.
//  - wrap also pulses every boundary when na=1.
//  Output arithmetic (registered, 1-cycle latency from idx/k/palette)
//  - STEP: out = pal[idx].
//  - FADE, per channel: out = c + ((n - c)*k >>> HOLD_LOG2).
//  - c = pal[idx], n = pal[nxt]; difference signed CW+1 bits; product CW+1+HOLD_LOG2 bits.
//  - Arithmetic shift floors toward -inf; result always stays in [min(c,n), max(c,n)].
//  - At k=0, out = c exactly; no overshoot; no wrap at 0 or 2**CW-1.
//  Palette writes
//  - Take effect on the clock edge; visible on outputs one cycle later.
//  - Apply even while OFF.
//  - A write coinciding with an index advance: write lands, advance proceeds unchanged.
// TESTING  (TICK_DIV=4, HOLD_LOG2=2, CW=8, N_COLORS=8)
//  1 Reset, en=1, mode=0, na=7:
//    - outputs {255,0,0}, then {255,60,0} after 16 clk; wrap pulses on return to idx 0 after 112 clk.
//  2 mode=1, pal0={0,0,0}, pal1={200,100,3}, na=2:
//    - outputs ramp k=0..3 to R 0,50,100,150; G 0,25,50,75; B 0,0,1,2.
//  3 Descending fade pal0={255,..}, pal1={0,..}:
//    - R 255,191,127,63; then 0 at idx=1; never exceeds 255 or underflows.
//  4 rst=0 asserted mid-fade at k=2:
//    - next cycle all outputs 0, color_idx=0, state OFF; en held 1 restarts from pal0.
//  5 na=0 -> behaves as 1: idx stays 0, wrap every 16 clk; na=9 -> clamps to 8.
//  6 pal_we to current idx during RUN:
//    - new value visible 1 cycle later; en=0 -> outputs 0 next cycle, idx held.

Source files
------------

// File: rtl/rgb_palette_sequencer.sv
// rtl/rgb_palette_sequencer.sv - palette-driven RGB duty sequencer with hard step or linear fade between entries
module rgb_palette_sequencer #(
    parameter int CW        = 8,
    parameter int N_COLORS  = 8,
    parameter int IW        = $clog2(N_COLORS),
    parameter int TICK_DIV  = 62_500_000,
    parameter int HOLD_LOG2 = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            mode,
    input  logic [IW:0]     n_active,
    input  logic            pal_we,
    input  logic [IW-1:0]   pal_addr,
    input  logic [3*CW-1:0] pal_data,
    output logic [CW-1:0]   r_out,
    output logic [CW-1:0]   g_out,
    output logic [CW-1:0]   b_out,
    output logic [IW-1:0]   color_idx,
    output logic            wrap
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int WP = CW + 1 + HOLD_LOG2;

    typedef enum logic {
        S_OFF,
        S_RUN
    } state_t;

    state_t               state;
    logic [PW-1:0]        presc;
    logic [HOLD_LOG2-1:0] k;
    logic [IW-1:0]        idx;
    logic                 mode_l;
    logic [3*CW-1:0]      pal [N_COLORS];

    logic [IW:0]          na;
    logic [IW-1:0]        nxt;
    logic                 tick;
    logic [3*CW-1:0]      src_col;
    logic [3*CW-1:0]      dst_col;
    logic [3*CW-1:0]      mix_col;
    logic [3*CW-1:0]      next_col;

    function automatic logic [CW-1:0] sc(input int v);
        sc = CW'(v << (CW - 8));
    endfunction

    function automatic logic [3*CW-1:0] def_color(input int i);
        int r, g, b;
        case (i)
            0:       begin r = 255; g = 0;   b = 0;   end
            1:       begin r = 255; g = 60;  b = 0;   end
            2:       begin r = 255; g = 255; b = 0;   end
            3:       begin r = 0;   g = 255; b = 0;   end
            4:       begin r = 0;   g = 0;   b = 255; end
            5:       begin r = 8;   g = 46;  b = 84;  end
            6:       begin r = 160; g = 32;  b = 240; end
            default: begin r = 0;   g = 0;   b = 0;   end
        endcase
        return {sc(r), sc(g), sc(b)};
    endfunction

    // Signed difference scaled by k; the arithmetic shift floors, so the result never leaves [min(c,n), max(c,n)].
    function automatic logic [CW-1:0] fade(input logic [CW-1:0] c, input logic [CW-1:0] n,
                                           input logic [HOLD_LOG2-1:0] kk);
        logic signed [CW:0]   diff;
        logic signed [WP-1:0] prod;
        logic signed [WP-1:0] sum;
        diff = $signed({1'b0, n}) - $signed({1'b0, c});
        prod = $signed({{HOLD_LOG2{diff[CW]}}, diff}) * $signed({{(CW + 1){1'b0}}, kk});
        sum  = $signed({{(HOLD_LOG2 + 1){1'b0}}, c}) + (prod >>> HOLD_LOG2);
        return CW'(sum);
    endfunction

    always_comb begin
        na = n_active;
        if (n_active == '0) begin
            na = (IW + 1)'(1);
        end else if (n_active > (IW + 1)'(N_COLORS)) begin
            na = (IW + 1)'(N_COLORS);
        end
    end

    always_comb begin
        nxt = idx + 1'b1;
        if ({1'b0, idx} >= na - 1'b1) begin
            nxt = '0;
        end
    end

    assign tick    = (state == S_RUN) && en && (presc == PW'(TICK_DIV - 1));
    assign src_col = pal[idx];
    assign dst_col = pal[nxt];

    always_comb begin
        mix_col = '0;
        for (int ch = 0; ch < 3; ch++) begin
            mix_col[ch*CW +: CW] = fade(src_col[ch*CW +: CW], dst_col[ch*CW +: CW], k);
        end
    end

    assign next_col  = mode_l ? mix_col : src_col;
    assign color_idx = idx;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= S_OFF;
            presc  <= '0;
            k      <= '0;
            idx    <= '0;
            mode_l <= 1'b0;
            wrap   <= 1'b0;
            r_out  <= '0;
            g_out  <= '0;
            b_out  <= '0;
            for (int i = 0; i < N_COLORS; i++) begin
                pal[i] <= def_color(i);
            end
        end else begin
            wrap <= 1'b0;
            if (pal_we && ({1'b0, pal_addr} < (IW + 1)'(N_COLORS))) begin
                pal[pal_addr] <= pal_data;
            end

            if (state == S_RUN && en) begin
                {r_out, g_out, b_out} <= next_col;
            end else begin
                {r_out, g_out, b_out} <= '0;
            end

            case (state)
                S_OFF: begin
                    presc <= '0;
                    k     <= '0;
                    if (en) begin
                        state  <= S_RUN;
                        mode_l <= mode;
                    end
                end
                S_RUN: begin
                    if (!en) begin
                        state <= S_OFF;
                        presc <= '0;
                        k     <= '0;
                    end else if (tick) begin
                        presc <= '0;
                        if (&k) begin
                            k      <= '0;
                            idx    <= nxt;
                            mode_l <= mode;
                            // Single-entry palettes still mark every colour boundary as a wrap.
                            wrap   <= (nxt == '0) && ((idx != '0) || (na == (IW + 1)'(1)));
                        end else begin
                            k <= k + 1'b1;
                        end
                    end else begin
                        presc <= presc + 1'b1;
                    end
                end
                default: state <= S_OFF;
            endcase
        end
    end

endmodule

// File: tb/tb_rgb_palette_sequencer.sv
// tb/tb_rgb_palette_sequencer.sv - self-checking bench for rgb_palette_sequencer
module tb_rgb_palette_sequencer;

    localparam int CW   = 8;
    localparam int NC   = 8;
    localparam int IW   = 3;
    localparam int TD   = 4;
    localparam int HL   = 2;
    localparam int HOLD = 1 << HL;
    localparam int PER  = TD * HOLD;

    logic            clk = 1'b0;
    logic            rst;
    logic            en;
    logic            mode;
    logic [IW:0]     n_active;
    logic            pal_we;
    logic [IW-1:0]   pal_addr;
    logic [3*CW-1:0] pal_data;
    logic [CW-1:0]   r_out;
    logic [CW-1:0]   g_out;
    logic [CW-1:0]   b_out;
    logic [IW-1:0]   color_idx;
    logic            wrap;

    always #5 clk = ~clk;

    rgb_palette_sequencer #(
        .CW(CW), .N_COLORS(NC), .IW(IW), .TICK_DIV(TD), .HOLD_LOG2(HL)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .n_active(n_active),
        .pal_we(pal_we), .pal_addr(pal_addr), .pal_data(pal_data),
        .r_out(r_out), .g_out(g_out), .b_out(b_out),
        .color_idx(color_idx), .wrap(wrap)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: a single run-time phase counter per colour and a plain integer palette.
    int m_pal [NC][3];
    int m_idx;
    int m_phase;
    bit m_run;
    bit m_mode;
    int e_r, e_g, e_b, e_idx;
    bit e_wrap;

    function automatic int floor_div(int a, int d);
        if (a >= 0) return a / d;
        return -((-a + d - 1) / d);
    endfunction

    function automatic int clamp_na(int v);
        if (v == 0) return 1;
        if (v > NC) return NC;
        return v;
    endfunction

    function automatic int model_chan(int c, int n, int kk, bit fade);
        if (!fade) return c;
        return c + floor_div((n - c) * kk, HOLD);
    endfunction

    task automatic m_reset();
        int d [NC][3];
        d = '{'{255,0,0}, '{255,60,0}, '{255,255,0}, '{0,255,0},
              '{0,0,255}, '{8,46,84}, '{160,32,240}, '{0,0,0}};
        for (int i = 0; i < NC; i++)
            for (int c = 0; c < 3; c++)
                m_pal[i][c] = d[i][c];
    endtask

    task automatic model_edge();
        int na, nxt, kk;
        if (!rst) begin
            m_reset();
            m_idx = 0; m_phase = 0; m_run = 0; m_mode = 0;
            e_r = 0; e_g = 0; e_b = 0; e_idx = 0; e_wrap = 0;
        end else begin
            na  = clamp_na(int'(n_active));
            nxt = (m_idx >= na - 1) ? 0 : m_idx + 1;
            kk  = m_phase / TD;
            if (m_run && en) begin
                e_r = model_chan(m_pal[m_idx][0], m_pal[nxt][0], kk, m_mode);
                e_g = model_chan(m_pal[m_idx][1], m_pal[nxt][1], kk, m_mode);
                e_b = model_chan(m_pal[m_idx][2], m_pal[nxt][2], kk, m_mode);
            end else begin
                e_r = 0; e_g = 0; e_b = 0;
            end
            e_wrap = 0;
            if (!m_run) begin
                if (en) begin
                    m_run = 1; m_mode = mode; m_phase = 0;
                end
            end else if (!en) begin
                m_run = 0; m_phase = 0;
            end else begin
                m_phase++;
                if (m_phase == PER) begin
                    m_phase = 0;
                    e_wrap  = (nxt == 0) && (m_idx != 0 || na == 1);
                    m_idx   = nxt;
                    m_mode  = mode;
                end
            end
            if (pal_we && int'(pal_addr) < NC) begin
                m_pal[pal_addr][0] = int'(pal_data[23:16]);
                m_pal[pal_addr][1] = int'(pal_data[15:8]);
                m_pal[pal_addr][2] = int'(pal_data[7:0]);
            end
            e_idx = m_idx;
        end
    endtask

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_col(string nm, logic [23:0] exp);
        check({nm, "_r"}, 32'(r_out), 32'(exp[23:16]));
        check({nm, "_g"}, 32'(g_out), 32'(exp[15:8]));
        check({nm, "_b"}, 32'(b_out), 32'(exp[7:0]));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("model_r", 32'(r_out), 32'(e_r));
        check("model_g", 32'(g_out), 32'(e_g));
        check("model_b", 32'(b_out), 32'(e_b));
        check("model_idx", 32'(color_idx), 32'(e_idx));
        check("model_wrap", 32'(wrap), 32'(e_wrap));
    endtask

    task automatic do_reset();
        rst = 1'b0; en = 1'b0; mode = 1'b0; pal_we = 1'b0;
        step();
        rst = 1'b1;
    endtask

    task automatic write_pal(logic [IW-1:0] a, logic [23:0] d);
        pal_we = 1'b1; pal_addr = a; pal_data = d;
        step();
        pal_we = 1'b0;
    endtask

    typedef struct packed {
        logic [23:0]      c;
        logic [23:0]      n;
        logic [3:0][23:0] e;
    } fade_vec_t;

    fade_vec_t fv [3];

    initial begin
        int got;
        fv[0] = '{c: 24'h000000, n: {8'd200, 8'd100, 8'd3},
                  e: {{8'd150, 8'd75, 8'd2}, {8'd100, 8'd50, 8'd1}, {8'd50, 8'd25, 8'd0}, {8'd0, 8'd0, 8'd0}}};
        fv[1] = '{c: {8'd255, 8'd128, 8'd7}, n: 24'h000000,
                  e: {{8'd63, 8'd32, 8'd1}, {8'd127, 8'd64, 8'd3}, {8'd191, 8'd96, 8'd5}, {8'd255, 8'd128, 8'd7}}};
        fv[2] = '{c: {8'd10, 8'd250, 8'd128}, n: {8'd250, 8'd10, 8'd128},
                  e: {{8'd190, 8'd70, 8'd128}, {8'd130, 8'd130, 8'd128}, {8'd70, 8'd190, 8'd128}, {8'd10, 8'd250, 8'd128}}};

        rst = 1'b0; en = 1'b0; mode = 1'b0; n_active = 4'd7;
        pal_we = 1'b0; pal_addr = '0; pal_data = '0;
        step();
        check_col("reset", 24'h000000);
        check("reset_idx", 32'(color_idx), 32'd0);
        rst = 1'b1;

        // Step mode through the default palette
        en = 1'b1; mode = 1'b0; n_active = 4'd7;
        step();
        step();
        check_col("step_first", 24'hFF0000);
        repeat (16) step();
        check_col("step_second", 24'hFF3C00);
        got = -1;
        for (int i = 1; i <= 200; i++) begin
            step();
            if (wrap) begin got = i; break; end
        end
        check("wrap_cycle", 32'(17 + got), 32'd112);

        // Fade ramps from the table
        for (int r = 0; r < 3; r++) begin
            do_reset();
            write_pal(3'd0, fv[r].c);
            write_pal(3'd1, fv[r].n);
            n_active = 4'd2; mode = 1'b1; en = 1'b1;
            step();
            for (int kk = 0; kk < HOLD; kk++) begin
                step();
                check_col($sformatf("fade%0d_k%0d", r, kk), fv[r].e[kk]);
                repeat (TD - 1) step();
            end
            step();
            check_col($sformatf("fade%0d_dst", r), fv[r].n);
            check($sformatf("fade%0d_idx", r), 32'(color_idx), 32'd1);
        end

        // Reset asserted mid-fade
        do_reset();
        write_pal(3'd0, fv[0].c);
        write_pal(3'd1, fv[0].n);
        n_active = 4'd2; mode = 1'b1; en = 1'b1;
        repeat (10) step();
        check_col("midfade_k2", fv[0].e[2]);
        rst = 1'b0;
        step();
        check_col("midfade_rst", 24'h000000);
        check("midfade_rst_idx", 32'(color_idx), 32'd0);
        rst = 1'b1;
        step();
        check_col("restart_off", 24'h000000);
        step();
        check_col("restart_pal0", 24'hFF0000);

        // n_active 0 behaves as 1, 9 clamps to 8
        do_reset();
        n_active = 4'd0; mode = 1'b0; en = 1'b1;
        got = -1;
        for (int i = 1; i <= 40; i++) begin
            step();
            if (wrap) begin got = i; break; end
        end
        check("na0_first_wrap_seen", 32'(got > 0), 32'd1);
        got = -1;
        for (int i = 1; i <= 40; i++) begin
            step();
            if (wrap) begin got = i; break; end
        end
        check("na0_wrap_period", 32'(got), 32'd16);
        check("na0_idx", 32'(color_idx), 32'd0);
        n_active = 4'd9;
        got = -1;
        for (int i = 1; i <= 300; i++) begin
            step();
            if (wrap) begin got = i; break; end
        end
        check("na9_wrap_period", 32'(got), 32'd128);

        // Write to the live entry, then disable
        do_reset();
        n_active = 4'd7; mode = 1'b0; en = 1'b1;
        repeat (21) step();
        check("live_idx", 32'(color_idx), 32'd1);
        write_pal(color_idx, 24'h123456);
        check_col("live_old", 24'hFF3C00);
        step();
        check_col("live_new", 24'h123456);
        en = 1'b0;
        step();
        check_col("disable_out", 24'h000000);
        repeat (3) step();
        check("disable_idx", 32'(color_idx), 32'd1);

        // Randomised run against the model
        do_reset();
        en = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            rst  = ($urandom_range(0, 299) != 0);
            en   = ($urandom_range(0, 59) != 0);
            mode = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 29) == 0) n_active = 4'($urandom_range(0, 15));
            pal_we   = ($urandom_range(0, 7) == 0);
            pal_addr = 3'($urandom_range(0, NC - 1));
            pal_data = 24'($urandom);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
